// File: rtl/addr_bus_pkg.sv
// Shared types and constants for the address-bus arbiter.
package addr_bus_pkg;

  localparam int NUM_REQ_DEFAULT = 5;
  localparam int ID_W            = 3;

  localparam int REQ_PC  = 0;
  localparam int REQ_INC = 1;
  localparam int REQ_J   = 2;
  localparam int REQ_XY  = 3;
  localparam int REQ_M   = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;

endpackage

// File: rtl/addr_bus_prio_pick.sv
// Combinational priority picker: first asserted request found when scanning
// upward from start_idx, wrapping from NUM_REQ-1 back to 0.
module addr_bus_prio_pick
  import addr_bus_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    start_idx,
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [ID_W-1:0]    win_idx
);

  logic            found;
  logic [ID_W-1:0] cand;
  int              k;

  // Scan all requesters once from the start index; the first hit wins.
  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    found      = 1'b0;
    cand       = '0;
    k          = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(start_idx) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      cand = ID_W'(k);
      if (!found && req[cand]) begin
        found            = 1'b1;
        win_onehot[cand] = 1'b1;
        win_idx          = cand;
      end
    end
  end

endmodule

// File: rtl/addr_bus_arbiter.sv
// Address-bus ownership sequencer: grant, settle, strobe, hold, dead cycle.
// Optional round-robin arbitration is enabled by defining ADDR_BUS_ROUND_ROBIN_EN;
// without it, the lowest requester index always wins.
//
//   state      | meaning
//   IDLE       | bus undriven, waiting for any request
//   SETTLE     | winner drives the bus, address settling
//   STROBE     | one-cycle sample pulse to memory and INC16
//   HOLD       | winner keeps the bus until it drops its request
//   RELEASE    | dead cycle, nobody drives (break-before-make)
module addr_bus_arbiter
  import addr_bus_pkg::*;
#(
  parameter int NUM_REQ       = NUM_REQ_DEFAULT,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    grant_id,
  output logic [NUM_REQ-1:0] drive_en,
  output logic               addr_strobe,
  output logic               busy
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   drive_en_q, drive_en_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic                 strobe_q, strobe_d;
  logic                 busy_q, busy_d;

  logic [NUM_REQ-1:0]   pick_onehot;
  logic [ID_W-1:0]      pick_idx;
  logic [ID_W-1:0]      pick_start;

`ifdef ADDR_BUS_ROUND_ROBIN_EN
  logic [ID_W-1:0]      ptr_q, ptr_d;

  // Pointer moves past every winner, aborted tenures included.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && |req)
      ptr_d = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign pick_start = ptr_q;
`else
  assign pick_start = '0;
`endif

  addr_bus_prio_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req        (req),
    .start_idx  (pick_start),
    .win_onehot (pick_onehot),
    .win_idx    (pick_idx)
  );

  // Next-state and next-output decode; every output is registered.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    drive_en_d = drive_en_q;
    grant_id_d = grant_id_q;
    strobe_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gnt_d      = pick_onehot;
          drive_en_d = pick_onehot;
          grant_id_d = pick_idx;
          cnt_d      = CNT_W'(SETTLE_CYCLES - 1);
          state_d    = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!req[grant_id_q]) begin
          state_d = ST_RELEASE;
        end else if (cnt_q == '0) begin
          strobe_d = 1'b1;
          state_d  = ST_STROBE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STROBE: state_d = ST_HOLD;
      ST_HOLD:   if (!req[grant_id_q]) state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (state_d == ST_RELEASE || state_d == ST_IDLE) begin
      gnt_d      = '0;
      drive_en_d = '0;
      grant_id_d = '0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      gnt_q      <= '0;
      drive_en_q <= '0;
      grant_id_q <= '0;
      strobe_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      drive_en_q <= drive_en_d;
      grant_id_q <= grant_id_d;
      strobe_q   <= strobe_d;
      busy_q     <= busy_d;
    end
  end

  assign gnt         = gnt_q;
  assign drive_en    = drive_en_q;
  assign grant_id    = grant_id_q;
  assign addr_strobe = strobe_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_addr_bus_arbiter.sv
// Bench for addr_bus_arbiter: two instances (settle 2 and settle 1) share one
// request bus and are compared every cycle against a tenure-age model.
module tb_addr_bus_arbiter;
  import addr_bus_pkg::*;

  localparam int N = 5;
`ifdef ADDR_BUS_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] gnt_a, drv_a, gnt_b, drv_b;
  logic [2:0]   id_a, id_b;
  logic         stb_a, stb_b, busy_a, busy_b;

  int tests = 0;
  int fails = 0;

  // Model: owner (-1 = none), cycles since grant, dead-cycle flag, RR pointer.
  int settle  [2] = '{2, 1};
  int m_owner [2];
  int m_age   [2];
  int m_dead  [2];
  int m_ptr   [2];

  always #5 clk = ~clk;

  addr_bus_arbiter #(.SETTLE_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt_a), .grant_id(id_a),
    .drive_en(drv_a), .addr_strobe(stb_a), .busy(busy_a));

  addr_bus_arbiter #(.SETTLE_CYCLES(1)) dut_b (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt_b), .grant_id(id_b),
    .drive_en(drv_b), .addr_strobe(stb_b), .busy(busy_b));

  function automatic int pick(input logic [N-1:0] r, input int start);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (start + k) % N;
      if (((r >> j) & 5'd1) != 5'd0) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_owner[i] = -1; m_age[i] = 0; m_dead[i] = 0; m_ptr[i] = 0;
    end
  endtask

  task automatic model_step(input logic [N-1:0] r);
    int w;
    for (int i = 0; i < 2; i++) begin
      if (m_owner[i] >= 0) begin
        if (((r >> m_owner[i]) & 5'd1) == 5'd0 && m_age[i] != settle[i]) begin
          m_owner[i] = -1; m_dead[i] = 1;
        end else begin
          m_age[i]++;
        end
      end else if (m_dead[i] != 0) begin
        m_dead[i] = 0;
      end else if (r != '0) begin
        w = pick(r, RR ? m_ptr[i] : 0);
        m_owner[i] = w; m_age[i] = 0; m_ptr[i] = (w + 1) % N;
      end
    end
  endtask

  task automatic chk(input string name, input int inst, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", name, inst, obs, exp);
    end
  endtask

  task automatic check_inst(input int i, input logic [N-1:0] g, input logic [N-1:0] d,
                            input logic [2:0] id, input logic s, input logic b);
    logic [N-1:0] eg;
    eg = (m_owner[i] >= 0) ? (5'd1 << m_owner[i]) : 5'd0;
    chk("gnt", i, 32'(g), 32'(eg));
    chk("drive_en", i, 32'(d), 32'(eg));
    chk("grant_id", i, 32'(id), (m_owner[i] >= 0) ? 32'(m_owner[i]) : 32'd0);
    chk("addr_strobe", i, 32'(s), 32'(m_owner[i] >= 0 && m_age[i] == settle[i]));
    chk("busy", i, 32'(b), 32'(m_owner[i] >= 0 || m_dead[i] != 0));
    chk("onehot", i, 32'($countones(d) <= 1), 32'd1);
  endtask

  task automatic check_all();
    check_inst(0, gnt_a, drv_a, id_a, stb_a, busy_a);
    check_inst(1, gnt_b, drv_b, id_b, stb_b, busy_b);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(req);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int strobe_at_a, strobe_at_b, strobes, ngrants, expected_id;
    logic [N-1:0] prev_g;
    int grants[$];

    // Reset state
    reset = 1'b1;
    req   = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    reset = 1'b0;
    cycle();
    cycle();

    // Single PC request: latency, strobe position, release and dead cycle
    req = 5'b00001;
    strobe_at_a = -1; strobe_at_b = -1;
    for (int c = 1; c <= 8; c++) begin
      cycle();
      if (stb_a) strobe_at_a = c;
      if (stb_b) strobe_at_b = c;
      if (c == 4) req = '0;
    end
    chk("strobe_cycle_s2", 0, 32'(strobe_at_a), 32'd3);
    chk("strobe_cycle_s1", 1, 32'(strobe_at_b), 32'd2);

    // XY and M together: XY first, M only after XY releases
    req = 5'b11000;
    grants.delete();
    prev_g = '0;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (gnt_a != '0 && prev_g == '0) grants.push_back(int'(id_a));
      prev_g = gnt_a;
      if (stb_a && id_a == 3'(REQ_XY)) req = 5'b10000;
      if (stb_a && id_a == 3'(REQ_M))  req = 5'b00000;
    end
    chk("xy_m_count", 0, 32'(grants.size()), 32'd2);
    if (grants.size() == 2) begin
      chk("xy_first", 0, 32'(grants[0]), 32'(REQ_XY));
      chk("m_second", 0, 32'(grants[1]), 32'(REQ_M));
    end
    for (int c = 0; c < 3; c++) cycle();

    // Abort in the first SETTLE cycle: no strobe, idle two cycles later
    req = 5'b00100;
    cycle();
    req = '0;
    strobes = 0;
    for (int c = 0; c < 4; c++) begin
      cycle();
      if (stb_a) strobes++;
      if (stb_b) strobes++;
      if (c == 1) chk("abort_idle", 0, 32'(busy_a), 32'd0);
    end
    chk("abort_no_strobe", 0, 32'(strobes), 32'd0);

    // Asynchronous reset mid-cycle while in HOLD
    req = 5'b00010;
    for (int c = 0; c < 5; c++) cycle();
    @(posedge clk);
    model_step(req);
    #2;
    reset = 1'b1;
    req   = '0;
    #1;
    chk("rst_gnt", 0, 32'(gnt_a), 32'd0);
    chk("rst_drive_en", 0, 32'(drv_a), 32'd0);
    chk("rst_busy", 0, 32'(busy_a), 32'd0);
    chk("rst_gnt", 1, 32'(gnt_b), 32'd0);
    chk("rst_busy", 1, 32'(busy_b), 32'd0);
    model_reset();
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_all();
    strobes = 0;
    for (int c = 0; c < 4; c++) begin
      cycle();
      if (stb_a || stb_b) strobes++;
    end
    chk("rst_no_strobe", 0, 32'(strobes), 32'd0);

    // All requesting, each tenure released after its strobe
    req = 5'b11111;
    grants.delete();
    prev_g = '0;
    ngrants = 0;
    for (int c = 0; c < 200 && grants.size() < 6; c++) begin
      cycle();
      if (gnt_a != '0 && prev_g == '0) grants.push_back(int'(id_a));
      prev_g = gnt_a;
      if (stb_a) req = 5'b11111 & ~(5'd1 << id_a);
      else if (busy_a && gnt_a == '0) req = 5'b11111;
    end
    ngrants = grants.size();
    chk("order_count", 0, 32'(ngrants), 32'd6);
    for (int g = 0; g < ngrants; g++) begin
      expected_id = RR ? (g % N) : 0;
      chk("grant_order", 0, 32'(grants[g]), 32'(expected_id));
    end
    req = '0;
    for (int c = 0; c < 8; c++) cycle();

    // Random request traffic against the model
    for (int c = 0; c < 800; c++) begin
      cycle();
      for (int b = 0; b < N; b++)
        if ($urandom_range(5) == 0) req[b] = ~req[b];
    end
    req = '0;
    for (int c = 0; c < 10; c++) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
